// File: rtl/seg7_scan_to_bcd.sv
// Recovers per-digit BCD values from a time-multiplexed 7-segment display bus.
// Define SEG7_ACTIVE_LOW_EN for common-anode buses (segment lit when 0).
module seg7_scan_to_bcd #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg,
  input  logic [NDIG-1:0]     dig_sel,
  input  logic                err_clr,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic [NDIG-1:0]     digit_valid,
  output logic                frame_done,
  output logic                err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_HOLD = 2'd2} state_t;

  localparam logic [3:0]      LP_STABLE = 4'(STABLE_CYC);
  localparam logic [NDIG-1:0] LP_ONE    = NDIG'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NDIG+6:0]     r_smp;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic [3:0]          r_mh_cnt;
  logic [3:0]          w_mh_cnt_nxt;
  logic [NDIG-1:0]     r_mask;
  logic [4*NDIG-1:0]   r_bcd;
  logic [NDIG-1:0]     r_valid;
  logic                r_frame_done;
  logic                r_err;

  logic [6:0]          w_seg;
  logic [NDIG+6:0]     w_in;
  logic                w_match;
  logic                w_onehot;
  logic                w_multi;
  logic                w_capture;
  logic                w_mh_err;
  logic [5:0]          w_dec;
  logic                w_err_set;
  logic                w_mask_full;
  logic [NDIG-1:0]     w_cap_bits;

  // Returns {valid, illegal, bcd}
  function automatic logic [5:0] f_decode(input logic [6:0] s);
    logic [5:0] d;
    case (s)
      7'h7E:   d = {1'b1, 1'b0, 4'h0};
      7'h30:   d = {1'b1, 1'b0, 4'h1};
      7'h6D:   d = {1'b1, 1'b0, 4'h2};
      7'h79:   d = {1'b1, 1'b0, 4'h3};
      7'h33:   d = {1'b1, 1'b0, 4'h4};
      7'h5B:   d = {1'b1, 1'b0, 4'h5};
      7'h5F:   d = {1'b1, 1'b0, 4'h6};
      7'h70:   d = {1'b1, 1'b0, 4'h7};
      7'h7F:   d = {1'b1, 1'b0, 4'h8};
      7'h7B:   d = {1'b1, 1'b0, 4'h9};
      7'h00:   d = {1'b0, 1'b0, 4'hF};
      default: d = {1'b0, 1'b1, 4'hE};
    endcase
    return d;
  endfunction

  function automatic logic f_onehot(input logic [NDIG-1:0] v);
    return (v != '0) && ((v & (v - LP_ONE)) == '0);
  endfunction

`ifdef SEG7_ACTIVE_LOW_EN
  assign w_seg = ~seg;
`else
  assign w_seg = seg;
`endif

  assign w_in        = {dig_sel, w_seg};
  assign w_match     = (w_in == r_smp);
  assign w_onehot    = f_onehot(dig_sel);
  assign w_multi     = (dig_sel != '0) && !w_onehot;
  assign w_dec       = f_decode(w_seg);
  assign w_err_set   = (w_capture && w_dec[4]) || w_mh_err;
  assign w_mask_full = (r_mask == '1);
  assign w_cap_bits  = w_capture ? dig_sel : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, dwell counter and capture strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 4'd0;
        if (w_onehot) begin
          w_state_nxt = S_SETTLE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (!w_match) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = w_onehot ? S_SETTLE : S_IDLE;
        end else if ((r_cnt + 4'd1) >= LP_STABLE) begin
          w_cnt_nxt   = LP_STABLE;
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      S_HOLD: begin
        if (!w_match) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = w_onehot ? S_SETTLE : S_IDLE;
        end else begin
          w_cnt_nxt   = LP_STABLE;
        end
      end
      default: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Multi-hot dwell tracking; saturation makes the error fire once per dwell
  always_comb begin
    w_mh_cnt_nxt = 4'd0;
    w_mh_err     = 1'b0;
    if (w_multi && w_match) begin
      if (r_mh_cnt < LP_STABLE) begin
        w_mh_cnt_nxt = r_mh_cnt + 4'd1;
        w_mh_err     = ((r_mh_cnt + 4'd1) == LP_STABLE);
      end else begin
        w_mh_cnt_nxt = r_mh_cnt;
      end
    end else begin
      w_mh_cnt_nxt = 4'd0;
    end
  end

  // Sampling, capture, frame tracking and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_smp        <= '0;
      r_cnt        <= 4'd0;
      r_mh_cnt     <= 4'd0;
      r_mask       <= '0;
      r_bcd        <= '1;
      r_valid      <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_smp        <= w_in;
      r_cnt        <= w_cnt_nxt;
      r_mh_cnt     <= w_mh_cnt_nxt;
      r_frame_done <= w_mask_full;
      r_mask       <= (w_mask_full ? '0 : r_mask) | w_cap_bits;
      for (int i = 0; i < NDIG; i++) begin
        if (w_cap_bits[i]) begin
          r_bcd[4*i +: 4] <= w_dec[3:0];
          r_valid[i]      <= w_dec[5];
        end
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end else begin
        r_err <= r_err;
      end
    end
  end

  assign bcd_out     = r_bcd;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign err         = r_err;

endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
// Scoreboard bench: a dwell-length reference model queues expected outputs per edge.
module tb_seg7_scan_to_bcd;
  localparam int NDIG = 4;
  localparam int SC   = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                err_clr = 1'b0;
  logic [6:0]          seg = 7'h00;
  logic [NDIG-1:0]     dig_sel = '0;
  logic [4*NDIG-1:0]   bcd_out;
  logic [NDIG-1:0]     digit_valid;
  logic                frame_done;
  logic                err;

  typedef struct packed {
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   vld;
    logic              fd;
    logic              er;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  logic [NDIG+6:0] m_prev;
  int              m_run;
  logic [NDIG-1:0] m_mask;
  exp_t            m_out;
  logic [6:0]      tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  always #5 clk = ~clk;

  seg7_scan_to_bcd #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel), .err_clr(err_clr),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .frame_done(frame_done), .err(err)
  );

  // 0..9 legal digit, 15 blank, 14 illegal
  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (tab[k] == s) return k;
    if (s == 7'h00) return 15;
    return 14;
  endfunction

  task automatic model_edge(input logic rst, input logic [NDIG-1:0] sel,
                            input logic [6:0] sg, input logic clr);
    logic            set_err;
    logic [NDIG-1:0] cap;
    int              d;
    if (!rst) begin
      m_prev = '0; m_run = 0; m_mask = '0;
      m_out.bcd = '1; m_out.vld = '0; m_out.fd = 1'b0; m_out.er = 1'b0;
      return;
    end
    if ({sel, sg} == m_prev) begin
      if (m_run < 1000) m_run = m_run + 1;
    end else begin
      m_run = 0;
    end
    m_prev  = {sel, sg};
    set_err = 1'b0;
    cap     = '0;
    if (m_run == SC) begin
      if ($countones(sel) == 1) begin
        cap = sel;
        d   = decode(sg);
        for (int i = 0; i < NDIG; i++) begin
          if (sel[i]) begin
            m_out.bcd[4*i +: 4] = 4'(d);
            m_out.vld[i]        = (d < 10);
          end
        end
        if (d == 14) set_err = 1'b1;
      end else if (sel != '0) begin
        set_err = 1'b1;
      end
    end
    m_out.fd = (m_mask == '1);
    m_mask   = (m_out.fd ? '0 : m_mask) | cap;
    if (set_err) m_out.er = 1'b1;
    else if (clr) m_out.er = 1'b0;
  endtask

  task automatic step(input logic rst, input logic [NDIG-1:0] sel,
                      input logic [6:0] sg, input logic clr);
    @(negedge clk);
    rst_n = rst; dig_sel = sel; seg = sg; err_clr = clr;
    model_edge(rst, sel, sg, clr);
    q.push_back(m_out);
  endtask

  task automatic hold(input logic [NDIG-1:0] sel, input logic [6:0] sg, input int n);
    for (int k = 0; k < n; k++) step(1'b1, sel, sg, 1'b0);
  endtask

  // Monitor: registered outputs are compared one step after each active edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_total = n_total + 1;
      if (bcd_out === e.bcd && digit_valid === e.vld && frame_done === e.fd && err === e.er) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL outputs t=%0t: got bcd=%h vld=%b fd=%b err=%b, expected bcd=%h vld=%b fd=%b err=%b",
                 $time, bcd_out, digit_valid, frame_done, err, e.bcd, e.vld, e.fd, e.er);
      end
    end
  end

  initial begin
    logic [NDIG-1:0] rs;
    logic [6:0]      rg;
    int              sel_kind, seg_kind;

    step(1'b0, '0, 7'h00, 1'b0);
    step(1'b0, '0, 7'h00, 1'b0);
    // single digit capture, then held
    hold(4'b0001, 7'h6D, 6);
    // full scan and frame_done
    hold(4'b0001, 7'h30, 4);
    hold(4'b0010, 7'h79, 4);
    hold(4'b0100, 7'h33, 4);
    hold(4'b1000, 7'h7B, 4);
    hold(4'b0000, 7'h00, 3);
    // glitch inside a dwell
    hold(4'b0010, 7'h5B, 2);
    hold(4'b0010, 7'h5F, 1);
    hold(4'b0010, 7'h5B, 4);
    // illegal, clear, blank
    hold(4'b0100, 7'h01, 4);
    step(1'b1, 4'b0100, 7'h01, 1'b1);
    hold(4'b0000, 7'h00, 2);
    hold(4'b0100, 7'h00, 4);
    // multi-hot dwell, then reset mid-dwell
    hold(4'b0011, 7'h30, 5);
    hold(4'b0010, 7'h5F, 2);
    step(1'b0, 4'b0010, 7'h5F, 1'b0);
    hold(4'b0010, 7'h5F, 2);
    hold(4'b0000, 7'h00, 2);

    // randomized dwells
    for (int n = 0; n < 400; n++) begin
      sel_kind = $urandom_range(0, 9);
      if (sel_kind < 7)       rs = NDIG'(1) << $urandom_range(0, NDIG - 1);
      else if (sel_kind == 7) rs = '0;
      else                    rs = NDIG'($urandom_range(0, (1 << NDIG) - 1));
      seg_kind = $urandom_range(0, 9);
      if (seg_kind < 7)       rg = tab[$urandom_range(0, 9)];
      else if (seg_kind == 7) rg = 7'h00;
      else                    rg = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 39) == 0) begin
        step(1'b0, rs, rg, 1'b0);
      end else begin
        step(1'b1, rs, rg, ($urandom_range(0, 5) == 0));
        hold(rs, rg, $urandom_range(0, 5));
      end
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_total = n_total + 1;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
